// File: rtl/radix_counter_pkg.sv
// Shared types, limits and the digit-width helper for the radix counter.
package radix_counter_pkg;

    localparam int MAX_DIGITS = 8;
    localparam int MAX_RADIX  = 16;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } count_dir_e;

    // Bits needed to hold one digit in 0..radix-1; never below one bit.
    function automatic int digit_w(input int radix);
        return (radix <= 2) ? 1 : $clog2(radix);
    endfunction

endpackage

// File: rtl/radix_counter_if.sv
// Bundles the control and status signals of one radix_counter instance.
interface radix_counter_if #(
    parameter int DIGITS = 2,
    parameter int RADIX  = 8
);
    import radix_counter_pkg::*;

    localparam int DIGIT_W = digit_w(RADIX);

    logic                      enable;
    logic                      load;
    logic [DIGITS*DIGIT_W-1:0] load_val;
    logic                      dir;
    logic [DIGITS*DIGIT_W-1:0] count;
    logic                      wrap;
    logic                      enable_sync;

    modport master (
        output enable, load, load_val, dir,
        input  count, wrap, enable_sync
    );

    modport slave (
        input  enable, load, load_val, dir,
        output count, wrap, enable_sync
    );

endinterface

// File: rtl/radix_digit.sv
// One digit of the radix counter: register, load clamp, terminal detect and
// carry/borrow out into the next digit.
module radix_digit
    import radix_counter_pkg::*;
#(
    parameter int RADIX   = 8,
    parameter int DIGIT_W = 3
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_load,
    input  logic [DIGIT_W-1:0] i_load_val,
    input  logic               i_step,
    input  count_dir_e         i_dir,
    output logic [DIGIT_W-1:0] o_digit,
    output logic               o_step
);

    localparam logic [DIGIT_W-1:0] LAST = DIGIT_W'(RADIX - 1);

    logic [DIGIT_W-1:0] r_digit;
    logic [DIGIT_W-1:0] w_next;
    logic [DIGIT_W-1:0] w_load;
    logic               w_term;

    // Terminal is the value that rolls over: top digit going up, zero going down.
    always_comb begin
        w_term = 1'b0;
        w_next = r_digit;
        if (i_dir == DIR_DOWN) begin
            w_term = (r_digit == '0);
            w_next = w_term ? LAST : r_digit - DIGIT_W'(1);
        end else begin
            w_term = (r_digit == LAST);
            w_next = w_term ? '0 : r_digit + DIGIT_W'(1);
        end
    end

    assign w_load = (i_load_val > LAST) ? LAST : i_load_val;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_digit <= '0;
        end else if (i_load) begin
            r_digit <= w_load;
        end else if (i_step) begin
            r_digit <= w_next;
        end
    end

    assign o_digit = r_digit;
    assign o_step  = i_step & w_term;

endmodule

// File: rtl/radix_counter.sv
// DIGITS-digit counter in base RADIX with load, wrap pulse and a synchronised
// enable. Define RADIX_COUNTER_DOWN_EN to honour i_dir (down-count/borrow).
module radix_counter
    import radix_counter_pkg::*;
#(
    parameter  int DIGITS  = 2,
    parameter  int RADIX   = 8,
    localparam int DIGIT_W = digit_w(RADIX)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_enable,
    input  logic                      i_load,
    input  logic [DIGITS*DIGIT_W-1:0] i_load_val,
    input  logic                      i_dir,
    output logic [DIGITS*DIGIT_W-1:0] o_count,
    output logic                      o_wrap,
    output logic                      o_enable_sync
);

    logic            r_sync1;
    logic            r_sync2;
    logic            r_wrap;
    logic [DIGITS:0] w_carry;
    count_dir_e      w_dir;

`ifdef RADIX_COUNTER_DOWN_EN
    assign w_dir = count_dir_e'(i_dir);
`else
    logic w_dir_unused;
    assign w_dir_unused = i_dir;
    assign w_dir        = DIR_UP;
`endif

    // i_enable comes from another domain, so it only acts after two flops.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_enable;
            r_sync2 <= r_sync1;
        end
    end

    assign w_carry[0] = r_sync2;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            radix_digit #(
                .RADIX   (RADIX),
                .DIGIT_W (DIGIT_W)
            ) u_digit (
                .i_clk      (i_clk),
                .i_rst      (i_rst),
                .i_load     (i_load),
                .i_load_val (i_load_val[gi*DIGIT_W +: DIGIT_W]),
                .i_step     (w_carry[gi]),
                .i_dir      (w_dir),
                .o_digit    (o_count[gi*DIGIT_W +: DIGIT_W]),
                .o_step     (w_carry[gi+1])
            );
        end
    endgenerate

    // A carry out of the top digit is exactly a full-count wrap in either direction.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_load) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_carry[DIGITS];
        end
    end

    assign o_wrap        = r_wrap;
    assign o_enable_sync = r_sync2;

endmodule

// File: tb/tb_radix_counter.sv
// Self-checking bench: integer-valued reference model per instance plus
// directed literal checks; default 2x octal and a 3-digit decimal instance.
module tb_radix_counter;

`ifdef RADIX_COUNTER_DOWN_EN
    localparam bit DOWN = 1'b1;
`else
    localparam bit DOWN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    radix_counter_if #(.DIGITS(2), .RADIX(8))  ifa ();
    radix_counter_if #(.DIGITS(3), .RADIX(10)) ifb ();

    radix_counter #(.DIGITS(2), .RADIX(8)) dut_a (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_enable      (ifa.enable),
        .i_load        (ifa.load),
        .i_load_val    (ifa.load_val),
        .i_dir         (ifa.dir),
        .o_count       (ifa.count),
        .o_wrap        (ifa.wrap),
        .o_enable_sync (ifa.enable_sync)
    );

    radix_counter #(.DIGITS(3), .RADIX(10)) dut_b (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_enable      (ifb.enable),
        .i_load        (ifb.load),
        .i_load_val    (ifb.load_val),
        .i_dir         (ifb.dir),
        .o_count       (ifb.count),
        .o_wrap        (ifb.wrap),
        .o_enable_sync (ifb.enable_sync)
    );

    // Reference model: count held as a plain integer 0..RADIX**DIGITS-1.
    int m_val   [2];
    bit m_wrap  [2];
    bit m_en_d1 [2];
    bit m_en_d2 [2];
    bit m_valid = 1'b0;

    function automatic logic [31:0] encode(input int v, input int r, input int d, input int w);
        logic [31:0] res = '0;
        int          x   = v;
        for (int i = 0; i < d; i++) begin
            res = res | (32'(x % r) << (i * w));
            x   = x / r;
        end
        return res;
    endfunction

    function automatic int load_value(input logic [31:0] bits, input int r, input int d, input int w);
        int val = 0;
        int mul = 1;
        for (int i = 0; i < d; i++) begin
            int f = int'((bits >> (i * w)) & ((32'd1 << w) - 32'd1));
            if (f >= r) f = r - 1;
            val = val + f * mul;
            mul = mul * r;
        end
        return val;
    endfunction

    task automatic model_step(input int k, input bit en, input bit ld, input logic [31:0] lv,
                              input bit dir, input int r, input int d, input int w);
        int  n = 1;
        bit  counting;
        for (int i = 0; i < d; i++) n = n * r;
        if (rst) begin
            m_val[k] = 0; m_wrap[k] = 0; m_en_d1[k] = 0; m_en_d2[k] = 0;
            return;
        end
        counting   = m_en_d2[k];
        m_en_d2[k] = m_en_d1[k];
        m_en_d1[k] = en;
        m_wrap[k]  = 1'b0;
        if (ld) begin
            m_val[k] = load_value(lv, r, d, w);
        end else if (counting) begin
            if (DOWN && dir) begin
                if (m_val[k] == 0) begin m_val[k] = n - 1; m_wrap[k] = 1'b1; end
                else m_val[k] = m_val[k] - 1;
            end else begin
                if (m_val[k] == n - 1) begin m_val[k] = 0; m_wrap[k] = 1'b1; end
                else m_val[k] = m_val[k] + 1;
            end
        end
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: advance the model at each edge, check outputs just after.
    always @(posedge clk) begin
        model_step(0, ifa.enable, ifa.load, 32'(ifa.load_val), ifa.dir, 8, 2, 3);
        model_step(1, ifb.enable, ifb.load, 32'(ifb.load_val), ifb.dir, 10, 3, 4);
        if (rst) m_valid = 1'b1;
        #2;
        if (m_valid) begin
            cmp("model_a_count", 32'(ifa.count), encode(m_val[0], 8, 2, 3));
            cmp("model_a_wrap",  32'(ifa.wrap),  32'(m_wrap[0]));
            cmp("model_a_sync",  32'(ifa.enable_sync), 32'(m_en_d2[0]));
            cmp("model_b_count", 32'(ifb.count), encode(m_val[1], 10, 3, 4));
            cmp("model_b_wrap",  32'(ifb.wrap),  32'(m_wrap[1]));
            cmp("model_b_sync",  32'(ifb.enable_sync), 32'(m_en_d2[1]));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_a(input string name, input logic [5:0] cnt, input bit wr, input bit sy);
        $display("txn %s: count=%o wrap=%0d sync=%0d", name, ifa.count, ifa.wrap, ifa.enable_sync);
        cmp({name, "_count"}, 32'(ifa.count), 32'(cnt));
        cmp({name, "_wrap"},  32'(ifa.wrap), 32'(wr));
        cmp({name, "_sync"},  32'(ifa.enable_sync), 32'(sy));
    endtask

    task automatic check_b(input string name, input logic [11:0] cnt, input bit wr);
        $display("txn %s: count=%h wrap=%0d", name, ifb.count, ifb.wrap);
        cmp({name, "_count"}, 32'(ifb.count), 32'(cnt));
        cmp({name, "_wrap"},  32'(ifb.wrap), 32'(wr));
    endtask

    initial begin
        ifa.enable = 0; ifa.load = 0; ifa.load_val = '0; ifa.dir = 0;
        ifb.enable = 0; ifb.load = 0; ifb.load_val = '0; ifb.dir = 0;
        rst = 1;
        tick(2);
        check_a("reset", 6'o00, 0, 0);
        check_b("reset_b", 12'h000, 0);

        // Enable lag: sync at edge 2, first count at edge 3, wrap after 64 steps.
        rst = 0; ifa.enable = 1;
        tick(1); check_a("en_e1", 6'o00, 0, 0);
        tick(1); check_a("en_e2", 6'o00, 0, 1);
        tick(1); check_a("en_e3", 6'o01, 0, 1);
        tick(62); check_a("en_top", 6'o77, 0, 1);
        tick(1); check_a("en_wrap", 6'o00, 1, 1);
        tick(1); check_a("en_after", 6'o01, 0, 1);

        // Load 77 then wrap on the next enabled edge.
        ifa.load = 1; ifa.load_val = 6'o77;
        tick(1); check_a("load77", 6'o77, 0, 1);
        ifa.load = 0;
        tick(1); check_a("load77_wrap", 6'o00, 1, 1);

        // Deassert enable at 05: two lag edges, then hold.
        ifa.load = 1; ifa.load_val = 6'o05;
        tick(1); check_a("load05", 6'o05, 0, 1);
        ifa.load = 0; ifa.enable = 0;
        tick(1); check_a("lag1", 6'o06, 0, 1);
        tick(1); check_a("lag2", 6'o07, 0, 0);
        tick(1); check_a("hold", 6'o07, 0, 0);

        // Direction: down-wrap from 0 when built with down support, else up.
        ifa.enable = 1; ifa.load = 1; ifa.load_val = 6'o00;
        tick(2); check_a("dir_pre", 6'o00, 0, 1);
        ifa.load = 0; ifa.dir = 1;
        tick(1);
        if (DOWN) check_a("dir_down", 6'o77, 1, 1);
        else      check_a("dir_ignored", 6'o01, 0, 1);
        ifa.dir = 0;
        tick(1);
        if (DOWN) check_a("dir_up", 6'o00, 1, 1);
        else      check_a("dir_up", 6'o02, 0, 1);

        // Reset beats load and enable; counting resumes three edges later.
        ifa.load = 1; ifa.load_val = 6'o33; rst = 1;
        tick(1); check_a("rst_prio", 6'o00, 0, 0);
        rst = 0; ifa.load = 0;
        tick(2); check_a("rst_resume2", 6'o00, 0, 1);
        tick(1); check_a("rst_resume3", 6'o01, 0, 1);
        ifa.enable = 0;

        // Decimal instance: per-digit clamp, carry across digits, full wrap.
        ifb.load = 1; ifb.load_val = 12'hC5F;
        tick(1); check_b("clamp", 12'h959, 0);
        ifb.load = 0; ifb.enable = 1;
        tick(3); check_b("carry", 12'h960, 0);
        ifb.load = 1; ifb.load_val = 12'h999;
        tick(1); check_b("load999", 12'h999, 0);
        ifb.load = 0;
        tick(1); check_b("wrap_b", 12'h000, 1);
        tick(1); check_b("after_b", 12'h001, 0);
        ifb.enable = 0;
        tick(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
